tdm_demux_frame: RTL

- Receive-side counterpart of the team's N:1 slot multiplexers.
- Accepts a time-division-multiplexed serial bit stream, one bit per slot, framed by a slot-0 marker.
- Steers each bit to its slot position and tracks frame alignment.
- Presents each completed frame as a parallel word with a one-cycle valid strobe.
- Sits between the serial link and the parallel control/status registers.

---
 rtl/tdm_demux_frame.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tdm_demux_frame.sv
// -----------------------------------------------------------------------------
// tdm_demux_frame
// Receive-side TDM demultiplexer. Takes a serial stream with one bit per slot,
// framed by a slot-0 marker, steers each bit into a shadow register at its slot
// position, and publishes each completed frame as a parallel word.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial slot data bit
//   din_valid    din carries a slot bit this cycle (a "beat")
//   frame_sync   current beat is slot 0 (ignored unless din_valid)
//   dout         last completed frame, bit k = slot k
//   frame_valid  one-cycle pulse when dout updates
//   slot_strb    one-hot of the slot written on the previous edge
//   slot_idx     next slot index expected
//   locked       high while frame-aligned
//   sync_err     one-cycle pulse on an alignment violation
//   frame_cnt    completed-frame count, wraps silently
//
// State table
//   state | meaning
//   HUNT  | not aligned; discard beats until a frame_sync beat arrives
//   RECV  | aligned; collecting slots 0..N_SLOTS-1 into the shadow register
// -----------------------------------------------------------------------------
module tdm_demux_frame #(
    parameter int N_SLOTS = 16,
    parameter int SEL_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [N_SLOTS-1:0] dout,
    output logic               frame_valid,
    output logic [N_SLOTS-1:0] slot_strb,
    output logic [SEL_W-1:0]   slot_idx,
    output logic               locked,
    output logic               sync_err,
    output logic [CNT_W-1:0]   frame_cnt
);

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t             state, state_nxt;
    logic [N_SLOTS-1:0] shadow, shadow_nxt;
    logic [N_SLOTS-1:0] dout_nxt;
    logic [N_SLOTS-1:0] strb_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               fv_nxt;
    logic               se_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            shadow      <= '0;
            dout        <= '0;
            slot_strb   <= '0;
            slot_idx    <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            dout        <= dout_nxt;
            slot_strb   <= strb_nxt;
            slot_idx    <= idx_nxt;
            frame_cnt   <= cnt_nxt;
            frame_valid <= fv_nxt;
            sync_err    <= se_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        dout_nxt   = dout;
        strb_nxt   = '0;
        idx_nxt    = slot_idx;
        cnt_nxt    = frame_cnt;
        fv_nxt     = 1'b0;
        se_nxt     = 1'b0;

        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_nxt[0] = din;
                        strb_nxt      = N_SLOTS'(1);
                        idx_nxt       = SLOT_ONE;
                        state_nxt     = RECV;
                    end
                end
                RECV: begin
                    if (frame_sync) begin
                        // A marker anywhere but slot 0 drops the partial frame
                        // and restarts alignment on this beat.
                        if (slot_idx != '0) se_nxt = 1'b1;
                        shadow_nxt[0] = din;
                        strb_nxt      = N_SLOTS'(1);
                        idx_nxt       = SLOT_ONE;
                    end else if (slot_idx == '0) begin
                        // Missing marker where slot 0 was due: alignment lost.
                        se_nxt    = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = HUNT;
                    end else begin
                        shadow_nxt[slot_idx] = din;
                        strb_nxt             = N_SLOTS'(1) << slot_idx;
                        if (slot_idx == LAST_SLOT) begin
                            // Last bit bypasses the shadow so dout is complete
                            // on the same edge that samples it.
                            dout_nxt = {din, shadow[N_SLOTS-2:0]};
                            fv_nxt   = 1'b1;
                            cnt_nxt  = frame_cnt + 1'b1;
                            idx_nxt  = '0;
                        end else begin
                            idx_nxt = slot_idx + 1'b1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked = (state == RECV);

endmodule
